// File: rtl/polaris_sequencer.sv
// Polaris CPU control sequencer: reset-vector load followed by one
// instruction fetch handshake, then a terminal JAM state because decode
// and execute do not exist yet.
// Optional build macro: SEQ_FETCH_TIMEOUT_EN adds a FETCH wait limit of
// FETCH_TIMEOUT cycles, after which the sequencer jams without loading IR/PC.
module polaris_sequencer #(
  parameter int unsigned FETCH_TIMEOUT = 256
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic rst,
  input  logic iack_i,
  output logic pc_mbvec,
  output logic pc_pcPlus4,
  output logic ir_idat,
  output logic iadr_pc,
  output logic isiz_2,
  output logic ft0_o,
  output logic jammed_o
);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_FETCH = 2'd1,
    ST_JAM   = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   ft0_q;
  logic   timeout;

  // A zero timeout would jam before the bus could ever answer.
  if (FETCH_TIMEOUT < 1) begin : g_bad_timeout
    $error("polaris_sequencer: FETCH_TIMEOUT must be at least 1");
  end

`ifdef SEQ_FETCH_TIMEOUT_EN
  localparam int unsigned CW = $clog2(FETCH_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FETCH_TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // The cycle that would bring the count to FETCH_TIMEOUT is the last one allowed.
  assign timeout = (cnt_q == CNT_LAST);

  // Count unanswered FETCH cycles; any other situation restarts from zero.
  always_comb begin
    cnt_d = '0;
    if (state_q == ST_FETCH && !rst && !iack_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Wait counter register.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  // State register plus the registered FETCH flag, which is loaded from
  // the next state so that it tracks the state flop exactly.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= ST_RESET;
      ft0_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ft0_q   <= (state_d == ST_FETCH);
    end
  end

  // Next-state logic: the synchronous reset request overrides every state.
  always_comb begin
    state_d = state_q;
    if (rst) begin
      state_d = ST_FETCH;
    end else begin
      unique case (state_q)
        ST_RESET: state_d = ST_FETCH;
        ST_FETCH: begin
          if (iack_i) begin
            state_d = ST_JAM;
          end else if (timeout) begin
            state_d = ST_JAM;
          end
        end
        ST_JAM:   state_d = ST_JAM;
        default:  state_d = ST_RESET;
      endcase
    end
  end

  // Mealy strobes from state, rst and iack_i; at most one PC and one IR select.
  always_comb begin
    pc_mbvec   = 1'b0;
    pc_pcPlus4 = 1'b0;
    ir_idat    = 1'b0;
    iadr_pc    = 1'b0;
    isiz_2     = 1'b0;
    jammed_o   = 1'b0;
    if (rst || state_q == ST_RESET) begin
      pc_mbvec = 1'b1;
    end else if (state_q == ST_FETCH) begin
      iadr_pc = 1'b1;
      isiz_2  = 1'b1;
      if (iack_i) begin
        ir_idat    = 1'b1;
        pc_pcPlus4 = 1'b1;
      end
    end else if (state_q == ST_JAM) begin
      jammed_o = 1'b1;
    end
  end

  assign ft0_o = ft0_q;

endmodule

// File: tb/tb_polaris_sequencer.sv
// Self-checking bench for polaris_sequencer: directed steps followed by
// random rst/iack/async-reset traffic, compared against a behavioural model.
module tb_polaris_sequencer;

  localparam int unsigned TIMEOUT = 4;

  logic clk_i = 1'b0;
  logic reset_i;
  logic rst;
  logic iack_i;
  logic pc_mbvec, pc_pcPlus4, ir_idat, iadr_pc, isiz_2, ft0_o, jammed_o;

  int checkCount = 0;
  int passCount  = 0;

  // Behavioural model: which phase the sequencer is in, and how long it has waited.
  bit mReset;
  bit mFetch;
  bit mJam;
  int mWait;

  polaris_sequencer #(.FETCH_TIMEOUT(TIMEOUT)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .rst        (rst),
    .iack_i     (iack_i),
    .pc_mbvec   (pc_mbvec),
    .pc_pcPlus4 (pc_pcPlus4),
    .ir_idat    (ir_idat),
    .iadr_pc    (iadr_pc),
    .isiz_2     (isiz_2),
    .ft0_o      (ft0_o),
    .jammed_o   (jammed_o)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk_i = ~clk_i;

  task automatic modelReset();
    mReset = 1'b1;
    mFetch = 1'b0;
    mJam   = 1'b0;
    mWait  = 0;
  endtask

  // Advance the model by one rising edge using the current inputs.
  task automatic modelStep();
    if (!reset_i) begin
      modelReset();
    end else if (rst || mReset) begin
      mReset = 1'b0;
      mFetch = 1'b1;
      mJam   = 1'b0;
      mWait  = 0;
    end else if (mFetch) begin
      if (iack_i) begin
        mFetch = 1'b0;
        mJam   = 1'b1;
      end else begin
        mWait = mWait + 1;
`ifdef SEQ_FETCH_TIMEOUT_EN
        if (mWait >= TIMEOUT) begin
          mFetch = 1'b0;
          mJam   = 1'b1;
        end
`endif
      end
    end
  endtask

  // Compare all outputs with what the model says the current cycle must show.
  task automatic checkOutput(input string tag);
    logic [6:0] got;
    logic [6:0] exp;
    bit active;
    active = !rst && mFetch;
    exp = {rst || mReset,
           active && iack_i,
           active && iack_i,
           active,
           active,
           mFetch,
           !rst && mJam};
    got = {pc_mbvec, pc_pcPlus4, ir_idat, iadr_pc, isiz_2, ft0_o, jammed_o};
    checkCount++;
    assert (got === exp) passCount++;
    else $error("FAIL %s got {mbvec,pc4,ir,iadr,isiz,ft0,jam}=%b expected %b", tag, got, exp);
  endtask

  // Entered at a falling edge: drive inputs, check mid-cycle, take the rising edge.
  task automatic applyStimulus(input logic r, input logic a, input string tag);
    rst    = r;
    iack_i = a;
    #1;
    checkOutput(tag);
    @(posedge clk_i);
    modelStep();
    @(negedge clk_i);
  endtask

  // Asynchronous reset pulse asserted mid-cycle, released at a later falling edge.
  task automatic asyncReset(input string tag);
    rst    = 1'b0;
    iack_i = 1'b0;
    #2;
    reset_i = 1'b0;
    modelReset();
    #1;
    checkOutput(tag);
    @(posedge clk_i);
    #1;
    checkOutput({tag, "_hold"});
    @(negedge clk_i);
    reset_i = 1'b1;
  endtask

  initial begin
    reset_i = 1'b0;
    rst     = 1'b0;
    iack_i  = 1'b0;
    modelReset();

    // Power-on reset held low across a rising edge.
    #2;
    checkOutput("por");
    @(negedge clk_i);
    checkOutput("por_hold");
    reset_i = 1'b1;

    // Leaving RESET, then the synchronous reset request for two cycles.
    applyStimulus(1'b0, 1'b0, "reset_state");
    applyStimulus(1'b0, 1'b0, "first_fetch");
    applyStimulus(1'b1, 1'b0, "rst_cycle1");
    applyStimulus(1'b1, 1'b1, "rst_cycle2");

    // Waiting fetch, then the acknowledge, then JAM ignoring iack pulses.
    applyStimulus(1'b0, 1'b0, "fetch_wait1");
    applyStimulus(1'b0, 1'b0, "fetch_wait2");
    applyStimulus(1'b0, 1'b0, "fetch_wait3");
    applyStimulus(1'b0, 1'b1, "fetch_ack");
    applyStimulus(1'b0, 1'b0, "jam");
    applyStimulus(1'b0, 1'b1, "jam_iack");
    applyStimulus(1'b0, 1'b1, "jam_iack2");

    // Leaving JAM through rst, then an aborted fetch (rst wins over iack).
    applyStimulus(1'b1, 1'b0, "jam_rst");
    applyStimulus(1'b1, 1'b1, "abort_fetch");
    applyStimulus(1'b0, 1'b1, "ack_after_abort");
    applyStimulus(1'b0, 1'b0, "jam_again");

    // Leaving JAM through the asynchronous reset.
    asyncReset("async_from_jam");
    applyStimulus(1'b0, 1'b0, "after_async");
    applyStimulus(1'b0, 1'b0, "fetch_after_async");

    // Long unanswered fetch: jams on the wait limit only when it is built in.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b0, $sformatf("long_wait%0d", i));
    end
    applyStimulus(1'b1, 1'b0, "rst_before_edge");

    // Acknowledge arriving on the last permitted wait cycle.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, $sformatf("edge_wait%0d", i));
    end
    applyStimulus(1'b0, 1'b1, "edge_ack");
    applyStimulus(1'b0, 1'b0, "edge_jam");

    // Random traffic with occasional synchronous and asynchronous resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        asyncReset($sformatf("rand_async%0d", i));
      end else begin
        applyStimulus(logic'($urandom_range(0, 11) == 0),
                      logic'($urandom_range(0, 2) == 0),
                      $sformatf("rand%0d", i));
      end
    end

    $display("[TB] random phase complete");
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
